// File: rtl/apb_fetch_unit.sv
// apb_fetch_unit
//   Instruction-fetch front end. It issues read-only APB fetches and buffers
//   the returned words in a DEPTH-entry prefetch FIFO. The core drains the
//   FIFO through a valid/ready handshake and redirects fetch on taken
//   branches and jumps.
//
// Ports
//   APB_PCLK, APB_PRESETn     clock and synchronous active-low reset
//   APB_paddr/psel/penable    APB master request (pwrite tied 0, pstb tied 1111)
//   APB_prdata/pready/perr    APB completion; perr is sampled with pready
//   redirect_valid/pc         flush the FIFO and restart fetch at redirect_pc
//   insn_valid/data/pc/err    FIFO head; insn_err marks a word fetched with perr
//   insn_ready                core accepts the head this cycle
//   level                     FIFO occupancy
//   halted                    a zero instruction word was consumed; fetch stopped
module apb_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         APB_PCLK,
    input  logic                         APB_PRESETn,
    output logic [ADDR_WIDTH-1:0]        APB_paddr,
    output logic                         APB_psel,
    output logic                         APB_penable,
    output logic                         APB_pwrite,
    output logic [3:0]                   APB_pstb,
    input  logic [DATA_WIDTH-1:0]        APB_prdata,
    input  logic                         APB_pready,
    input  logic                         APB_perr,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         insn_valid,
    output logic [DATA_WIDTH-1:0]        insn_data,
    output logic [ADDR_WIDTH-1:0]        insn_pc,
    output logic                         insn_err,
    input  logic                         insn_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         halted
);

    localparam int STEP = DATA_WIDTH / 8;
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   fpc_reg, fpc_next;
    logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
    logic                    stall_reg, stall_next;
    logic                    discard_reg, discard_next;
    logic                    halted_reg, halted_next;
    logic [LW-1:0]           level_reg, level_next;
    logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg;

    logic [DATA_WIDTH-1:0]   mem_data [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_pc   [DEPTH];
    logic [DEPTH-1:0]        mem_err;

    logic                    redir, complete, push, pop, halt_set, issue_ok;
    logic [ADDR_WIDTH-1:0]   redirect_aligned;

    // Once halted the redirect input is ignored entirely.
    assign redir            = redirect_valid && !halted_reg;
    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(STEP - 1);
    assign complete         = (state_reg == ACCESS) && APB_pready;
    assign pop              = insn_valid && insn_ready;
    assign halt_set         = pop && !redir && (insn_data == '0) && !insn_err;
    assign halted_next      = halted_reg || halt_set;
    // A redirect or halt in the completion cycle drops the returning word.
    assign push             = complete && !discard_reg && !redir && !halted_next;

    always_comb begin
        level_next   = level_reg;
        stall_next   = stall_reg;
        discard_next = discard_reg;
        fpc_next     = fpc_reg;
        if (redir) begin
            level_next = '0;
            stall_next = 1'b0;
            fpc_next   = redirect_aligned;
        end else begin
            level_next = level_reg + LW'(push) - LW'(pop);
            if (push && APB_perr)
                stall_next = 1'b1;
            if (complete && !discard_reg)
                fpc_next = fpc_reg + ADDR_WIDTH'(STEP);
        end
        // A transfer caught by a redirect still finishes on the bus; its
        // data is dropped when it completes.
        if (complete)
            discard_next = 1'b0;
        else if (redir && state_reg != IDLE)
            discard_next = 1'b1;
    end

    // Reservation check uses the post-update occupancy; any transfer still
    // on the bus at this point is the one completing this cycle, already
    // reflected in level_next.
    assign issue_ok = (level_next < LW'(DEPTH)) && !stall_next && !halted_next && !redir;

    always_comb begin
        state_next = state_reg;
        paddr_next = paddr_reg;
        case (state_reg)
            IDLE: begin
                if (issue_ok) begin
                    state_next = SETUP;
                    paddr_next = fpc_next;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (APB_pready) begin
                    if (issue_ok) begin
                        state_next = SETUP;
                        paddr_next = fpc_next;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge APB_PCLK) begin
        if (!APB_PRESETn) begin
            state_reg   <= IDLE;
            fpc_reg     <= RESET_PC;
            paddr_reg   <= RESET_PC;
            stall_reg   <= 1'b0;
            discard_reg <= 1'b0;
            halted_reg  <= 1'b0;
            level_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            fpc_reg     <= fpc_next;
            paddr_reg   <= paddr_next;
            stall_reg   <= stall_next;
            discard_reg <= discard_next;
            halted_reg  <= halted_next;
            level_reg   <= level_next;
            if (redir) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    // FIFO storage; entries are cleared on reset so the head reads as zero.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge APB_PCLK) begin
                if (!APB_PRESETn) begin
                    mem_data[gi] <= '0;
                    mem_pc[gi]   <= '0;
                    mem_err[gi]  <= 1'b0;
                end else if (push && wr_ptr_reg == PW'(gi)) begin
                    mem_data[gi] <= APB_prdata;
                    mem_pc[gi]   <= paddr_reg;
                    mem_err[gi]  <= APB_perr;
                end
            end
        end
    endgenerate

    assign APB_paddr   = paddr_reg;
    assign APB_psel    = (state_reg != IDLE);
    assign APB_penable = (state_reg == ACCESS);
    assign APB_pwrite  = 1'b0;
    assign APB_pstb    = 4'b1111;

    assign insn_valid  = (level_reg != '0) && !halted_reg;
    assign insn_data   = mem_data[rd_ptr_reg];
    assign insn_pc     = mem_pc[rd_ptr_reg];
    assign insn_err    = mem_err[rd_ptr_reg];
    assign level       = level_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_apb_fetch_unit.sv
// Testbench for apb_fetch_unit: an APB slave model answering addr+1 with
// programmable wait states, error address and zero-word address, plus a
// scoreboard of expected FIFO words compared at each handshake.
module tb_apb_fetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [AW-1:0]  paddr;
    logic           psel, penable, pwrite;
    logic [3:0]     pstb;
    logic [DW-1:0]  prdata = '0;
    logic           pready = 1'b0;
    logic           perr = 1'b0;
    logic           redirect_valid = 1'b0;
    logic [AW-1:0]  redirect_pc = '0;
    logic           insn_valid;
    logic [DW-1:0]  insn_data;
    logic [AW-1:0]  insn_pc;
    logic           insn_err;
    logic           insn_ready = 1'b0;
    logic [LW-1:0]  level;
    logic           halted;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
        logic          err;
    } exp_t;

    exp_t           exp_q[$];
    int             pop_cyc[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             setup_cnt = 0;
    int             pop_cnt = 0;
    logic [AW-1:0]  last_setup_addr = '0;
    int             waits = 0;
    int             wait_cnt = 0;
    logic           err_en = 1'b0;
    logic [AW-1:0]  err_addr = '0;
    logic           zero_en = 1'b0;
    logic [AW-1:0]  zero_addr = '0;

    apb_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .APB_PCLK       (clk),
        .APB_PRESETn    (rstn),
        .APB_paddr      (paddr),
        .APB_psel       (psel),
        .APB_penable    (penable),
        .APB_pwrite     (pwrite),
        .APB_pstb       (pstb),
        .APB_prdata     (prdata),
        .APB_pready     (pready),
        .APB_perr       (perr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_data      (insn_data),
        .insn_pc        (insn_pc),
        .insn_err       (insn_err),
        .insn_ready     (insn_ready),
        .level          (level),
        .halted         (halted)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input logic [AW-1:0] pc, input logic er);
        exp_t e;
        e.data = d;
        e.pc   = pc;
        e.err  = er;
        exp_q.push_back(e);
    endtask

    // One clock cycle: at the falling edge observe the bus and handshake,
    // update the slave model, then return just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (psel && !penable) begin
            setup_cnt++;
            last_setup_addr = paddr;
        end
        if (insn_valid && insn_ready) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            check("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("pop cyc=%0d data=0x%0h pc=0x%0h err=%0b", cyc, insn_data, insn_pc, insn_err);
                check("insn_data", insn_data, e.data);
                check("insn_pc", insn_pc, e.pc);
                check("insn_err", insn_err, e.err);
            end
        end
        if (psel && penable) begin
            if (wait_cnt >= waits) begin
                pready = 1'b1;
                prdata = (zero_en && paddr == zero_addr) ? '0 : paddr + 32'd1;
                perr   = err_en && (paddr == err_addr);
            end else begin
                pready = 1'b0;
                wait_cnt++;
            end
        end else begin
            pready   = 1'b0;
            perr     = 1'b0;
            wait_cnt = 0;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_pstb", pstb, 4'hF);
        check("rst_insn_valid", insn_valid, 0);
        check("rst_insn_data", insn_data, 0);
        check("rst_insn_pc", insn_pc, 0);
        check("rst_insn_err", insn_err, 0);
        check("rst_level", level, 0);
        check("rst_halted", halted, 0);
        rstn = 1'b1;
    endtask

    task automatic pop_one(input logic [DW-1:0] d, input logic [AW-1:0] pc, input logic er);
        int n;
        n = 0;
        expect_word(d, pc, er);
        while (!insn_valid && n < 60) begin
            tick();
            n++;
        end
        check("pop_wait_valid", insn_valid, 1);
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
    endtask

    initial begin
        int n, base_s, base_p, sz;
        @(posedge clk);
        #2;

        // 1: zero-wait slave, always ready: one word every two cycles
        waits = 0;
        insn_ready = 1'b1;
        do_reset();
        check("t1_idle_at_release", psel, 0);
        tick();
        check("t1_setup_psel", psel, 1);
        check("t1_setup_penable", penable, 0);
        check("t1_setup_paddr", paddr, 32'h0);
        expect_word(32'h1, 32'h0, 1'b0);
        expect_word(32'h5, 32'h4, 1'b0);
        expect_word(32'h9, 32'h8, 1'b0);
        base_p = pop_cnt;
        n = 0;
        while (pop_cnt - base_p < 3 && n < 40) begin
            tick();
            n++;
        end
        insn_ready = 1'b0;
        check("t1_three_pops", pop_cnt - base_p, 3);
        sz = pop_cyc.size();
        if (sz >= 3) begin
            check("t1_gap_a", pop_cyc[sz-2] - pop_cyc[sz-3], 2);
            check("t1_gap_b", pop_cyc[sz-1] - pop_cyc[sz-2], 2);
        end
        check("t1_sb_drained", exp_q.size(), 0);

        // 2: consumer stalled: exactly DEPTH fetches, then one per pop
        do_reset();
        base_s = setup_cnt;
        repeat (20) tick();
        check("t2_setups", setup_cnt - base_s, 4);
        check("t2_level_full", level, 4);
        check("t2_psel_idle", psel, 0);
        expect_word(32'h1, 32'h0, 1'b0);
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        check("t2_level_after_pop", level, 3);
        check("t2_refetch_psel", psel, 1);
        repeat (10) tick();
        check("t2_setups_after", setup_cnt - base_s, 5);
        check("t2_level_refull", level, 4);
        check("t2_psel_idle2", psel, 0);
        check("t2_sb_drained", exp_q.size(), 0);

        // 3: redirect during a wait-stated ACCESS at 0x8
        waits = 3;
        do_reset();
        n = 0;
        while (!(psel && penable && paddr == 32'h8) && n < 60) begin
            tick();
            n++;
        end
        check("t3_access_at_8", (psel && penable && paddr == 32'h8), 1);
        check("t3_level_before", level, 2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("t3_flush_level", level, 0);
        check("t3_transfer_continues", (psel && penable), 1);
        base_s = setup_cnt;
        n = 0;
        while (setup_cnt == base_s && n < 30) begin
            tick();
            n++;
        end
        check("t3_next_setup_addr", last_setup_addr, 32'h100);
        check("t3_level_after_discard", level, 0);
        pop_one(32'h101, 32'h100, 1'b0);
        check("t3_sb_drained", exp_q.size(), 0);

        // 4: bus error on 0xC stalls fetch until a redirect
        waits = 0;
        err_en = 1'b1;
        err_addr = 32'hC;
        do_reset();
        repeat (16) tick();
        check("t4_level_full", level, 4);
        base_s = setup_cnt;
        pop_one(32'h1, 32'h0, 1'b0);
        pop_one(32'h5, 32'h4, 1'b0);
        pop_one(32'h9, 32'h8, 1'b0);
        pop_one(32'hD, 32'hC, 1'b1);
        repeat (8) tick();
        check("t4_stalled_no_setup", setup_cnt - base_s, 0);
        check("t4_psel_idle", psel, 0);
        check("t4_level_empty", level, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        err_en = 1'b0;
        tick();
        check("t4_resume_psel", psel, 1);
        check("t4_resume_paddr", paddr, 32'h40);
        pop_one(32'h41, 32'h40, 1'b0);
        check("t4_sb_drained", exp_q.size(), 0);

        // 5: zero word at 0x10 halts; redirect ignored; reset clears
        waits = 1;
        zero_en = 1'b1;
        zero_addr = 32'h10;
        do_reset();
        repeat (20) tick();
        pop_one(32'h1, 32'h0, 1'b0);
        pop_one(32'h5, 32'h4, 1'b0);
        pop_one(32'h9, 32'h8, 1'b0);
        pop_one(32'hD, 32'hC, 1'b0);
        pop_one(32'h0, 32'h10, 1'b0);
        check("t5_halted", halted, 1);
        check("t5_valid_forced_low", insn_valid, 0);
        repeat (10) tick();
        base_s = setup_cnt;
        check("t5_psel_idle", psel, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();
        check("t5_no_setup_after_redirect", setup_cnt - base_s, 0);
        check("t5_psel_still_idle", psel, 0);
        check("t5_still_halted", halted, 1);
        check("t5_valid_still_low", insn_valid, 0);
        zero_en = 1'b0;
        do_reset();
        check("t5_reset_clears_halt", halted, 0);
        check("t5_sb_drained", exp_q.size(), 0);

        // 6: push and pop in the same cycle, then redirect with a pop
        waits = 3;
        do_reset();
        n = 0;
        while (!(psel && penable && level == 2) && n < 60) begin
            tick();
            n++;
        end
        check("t6_reach_level2_access", (psel && penable && level == 2), 1);
        tick();
        tick();
        tick();
        check("t6_level_before", level, 2);
        expect_word(32'h1, 32'h0, 1'b0);
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        check("t6_level_push_pop", level, 2);
        expect_word(32'h5, 32'h4, 1'b0);
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        insn_ready = 1'b0;
        redirect_valid = 1'b0;
        check("t6_level_redirect_pop", level, 0);
        check("t6_valid_after_redirect", insn_valid, 0);
        check("t6_sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_fetch_unit.md
# apb_fetch_unit

Parametrised instruction-fetch front end for the multi-cycle RISC-V core. It drives an APB master port for read-only instruction fetches and buffers the fetched words in a DEPTH-entry prefetch FIFO. The core consumes the FIFO through a valid/ready interface and redirects fetch on taken branches and jumps. Unlike the core's single saved-instruction register, this block keeps fetches in flight, flushes on redirect, tags bus errors per entry, and stops fetching on a zero instruction word.

## Interface
- ADDR_WIDTH, 32, APB address and PC width
- DATA_WIDTH, 32, instruction word width; PC step is DATA_WIDTH/8
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

- APB_PCLK  in  1  single clock; all state updates on rising edge
- APB_PRESETn  in  1  reset, synchronous, active-low
- APB_paddr  out  ADDR_WIDTH  fetch address
- APB_psel  out  1  APB select
- APB_penable  out  1  APB enable (access phase)
- APB_pwrite  out  1  tied 0
- APB_pstb  out  4  tied 4'b1111 (read strobes)
- APB_prdata  in  DATA_WIDTH  read data
- APB_pready  in  1  transfer completion
- APB_perr  in  1  transfer error, sampled with pready
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- insn_valid  out  1  FIFO head valid
- insn_data  out  DATA_WIDTH  head instruction word
- insn_pc  out  ADDR_WIDTH  address of head word
- insn_err  out  1  head word fetch returned perr
- insn_ready  in  1  core accepts head this cycle
- level  out  $clog2(DEPTH+1)  current FIFO occupancy
- halted  out  1  zero instruction consumed; fetch stopped

## Operation
- APB FSM states: IDLE, SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
- IDLE→SETUP when `level + inflight < DEPTH`, `!stall`, `!halted`, and no redirect this cycle. paddr is loaded with fpc on SETUP entry and stays stable through ACCESS.
- SETUP→ACCESS unconditionally.
- ACCESS holds until pready. On pready: FSM goes to SETUP if the issue condition still holds, otherwise to IDLE. fpc advances by DATA_WIDTH/8.
- On completion, push {prdata, paddr, perr} unless the discard flag is set. If perr, set stall: no further issue until a redirect.
- Redirect: flush the FIFO (level←0), fpc←aligned redirect_pc, clear stall. If a transfer is in SETUP/ACCESS, it completes on the bus per APB rules; set discard so its data is dropped and fpc is not advanced by it. Discard clears on that completion.
- Redirect beats a same-cycle pop and a same-cycle push; the FIFO is empty afterwards.
- Pop on insn_valid && insn_ready. Push and pop may occur in the same cycle; level is unchanged.
- Reservation (level + inflight) guarantees a push never hits a full FIFO. Pop from empty cannot occur since insn_valid=0.
- Halt: a pop with insn_data==0 and insn_err==0 sets halted. Once halted: insn_valid forced 0, no new SETUP; any in-flight transfer completes and is discarded. Only reset clears halted; redirect does not.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset (APB_PRESETn=0 at edge): psel=0, penable=0, paddr=RESET_PC, fpc=RESET_PC, insn_valid=0, insn_data=0, insn_pc=0, insn_err=0, level=0, halted=0, stall=0, discard=0. Reset mid-transfer aborts it immediately; the APB slave must tolerate this.
- First cycle after reset release: SETUP at RESET_PC.
- Zero-wait slave: 2 cycles per word, back-to-back SETUP after ACCESS with no IDLE. Sustained throughput is 1 word / 2 cycles.
- Push latency: word captured on the pready edge; insn_valid=1 in the following cycle. FIFO head is registered (no comb path from prdata to insn_*).
- Redirect latency: the edge where redirect_valid=1 flushes; the earliest SETUP at the new pc is the next cycle if idle, otherwise after the discarded transfer completes.

## Test plan
- Reset, zero-wait slave returning addr+1, insn_ready=1 -> SETUP at 0x0 cycle 1; words 0x1,0x5,0x9 with insn_pc 0x0,0x4,0x8, one every 2 cycles.
- insn_ready=0, DEPTH=4 -> exactly 4 transfers issued, level=4, psel stays 0; raising ready for 1 cycle -> exactly one new fetch issued.
- Slave with 3 wait states; redirect_valid with redirect_pc=0x103 during ACCESS at 0x8 -> transfer completes, data dropped, next SETUP paddr=0x100, first insn_pc=0x100.
- perr on fetch of 0xC -> entry insn_err=1, insn_pc=0xC, no further psel until redirect to 0x40, then fetch resumes at 0x40.
- Word 0 at 0x10 -> after pop of 0x10, halted=1 and insn_valid=0; redirect ignored; psel stays 0 after the in-flight transfer; reset clears halted.
- Push and pop in the same cycle at level=2 -> level stays 2; redirect in same cycle as pop -> level=0.
